// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD1602 bus arbiter: controller states,
// the fixed HD44780 init command sequence and the row address commands
// that display-content requesters use to position the cursor.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_PWRUP = 2'd0,
    ST_INIT  = 2'd1,
    ST_IDLE  = 2'd2,
    ST_WRITE = 2'd3
  } lcd_state_e;

  localparam int INIT_LEN = 5;

  // 8-bit interface, 2 lines, 5x8 font
  localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
  // display off while the controller is configured
  localparam logic [7:0] CMD_DISP_OFF   = 8'h08;
  // clear display, cursor home (slowest command)
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  // increment cursor, no display shift
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
  // display on, cursor and blink off
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;

  // Set-DDRAM-address commands for the start of each row
  localparam logic [7:0] ROW0_ADDR = 8'h80;
  localparam logic [7:0] ROW1_ADDR = 8'hC0;

  // Init command for a given step of the power-up sequence
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = CMD_FUNC_SET;
      3'd1:    init_cmd = CMD_DISP_OFF;
      3'd2:    init_cmd = CMD_CLEAR;
      3'd3:    init_cmd = CMD_ENTRY_MODE;
      default: init_cmd = CMD_DISP_ON;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: first active request after the pointer wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_vld
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  // Scan ptr+1, ptr+2, ... wrapping, so the last winner has lowest priority
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!gnt_vld && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        gnt_vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// LCD1602 bus owner: power-up wait, fixed init sequence, then round-robin writes.
// Latency: req_ready in the same IDLE cycle as req_valid; lcd_en rises the next cycle.
// Backpressure: one write per T_CYCLE+1 cycles; requesters hold req_valid until ready.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int T_PWRUP = 1_000_000,
  parameter int T_CYCLE = 100_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_rs,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       init_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       lcd_en,
  output logic                       lcd_rw,
  output logic                       lcd_rs,
  output logic [7:0]                 lcd_data
);

  localparam int          IDX_W      = $clog2(NUM_REQ);
  localparam logic [31:0] PWRUP_LAST = 32'(T_PWRUP - 1);
  localparam logic [31:0] CYC_LAST   = 32'(T_CYCLE - 1);
  localparam logic [31:0] EN_HIGH    = 32'(T_CYCLE / 2);
  localparam logic [2:0]  INIT_LAST  = 3'(INIT_LEN - 1);

  lcd_state_e       state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [2:0]       init_idx_q, init_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic             lcd_en_q, lcd_en_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [7:0]       lcd_data_q, lcd_data_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Next-state logic; lcd_en is decoded from the next state so the pin is a clean flop output
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    init_idx_d = init_idx_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_data_d = lcd_data_q;
    req_ready  = '0;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d    = ST_INIT;
          cnt_d      = '0;
          init_idx_d = '0;
          lcd_rs_d   = 1'b0;
          lcd_data_d = init_cmd(3'd0);
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_INIT: begin
        if (cnt_q == CYC_LAST) begin
          cnt_d = '0;
          if (init_idx_q == INIT_LAST) begin
            state_d = ST_IDLE;
          end else begin
            init_idx_d = init_idx_q + 3'd1;
            lcd_data_d = init_cmd(init_idx_q + 3'd1);
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_IDLE: begin
        if (arb_vld) begin
          req_ready  = arb_gnt;
          lcd_rs_d   = req_rs[arb_idx];
          lcd_data_d = req_data[{arb_idx, 3'b000} +: 8];
          grant_id_d = arb_idx;
          ptr_d      = arb_idx;
          state_d    = ST_WRITE;
          cnt_d      = '0;
        end
      end
      ST_WRITE: begin
        if (cnt_q == CYC_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_PWRUP;
        cnt_d   = '0;
      end
    endcase

    lcd_en_d = ((state_d == ST_INIT) || (state_d == ST_WRITE)) && (cnt_d < EN_HIGH);
  end

  // State and bus registers; reset drops the LCD pins immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PWRUP;
      cnt_q      <= '0;
      init_idx_q <= '0;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      grant_id_q <= '0;
      lcd_en_q   <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      init_idx_q <= init_idx_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      lcd_en_q   <= lcd_en_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_data_q <= lcd_data_d;
    end
  end

  // Init can only complete once, so being past INIT is the same as init_done
  assign init_done = (state_q == ST_IDLE) || (state_q == ST_WRITE);
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = grant_id_q;
  assign lcd_en    = lcd_en_q;
  assign lcd_rw    = 1'b0;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_data  = lcd_data_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with short power-up and write timing.
// Each task drives one scenario and compares against hand-computed values.
// Outputs are sampled on the falling clock edge.
module tb_lcd_bus_arbiter;

  localparam int NUM_REQ = 2;
  localparam int T_PWRUP = 16;
  localparam int T_CYCLE = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_rs = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ready;
  logic        init_done;
  logic        busy;
  logic        grant_id;
  logic        lcd_en;
  logic        lcd_rw;
  logic        lcd_rs;
  logic [7:0]  lcd_data;

  int n_cmp = 0;
  int n_bad = 0;

  lcd_bus_arbiter #(
    .NUM_REQ (NUM_REQ),
    .T_PWRUP (T_PWRUP),
    .T_CYCLE (T_CYCLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .req_ready (req_ready),
    .init_done (init_done),
    .busy      (busy),
    .grant_id  (grant_id),
    .lcd_en    (lcd_en),
    .lcd_rw    (lcd_rw),
    .lcd_rs    (lcd_rs),
    .lcd_data  (lcd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(output int w);
    w = 0;
    while (busy !== 1'b0 && w < 200) begin
      step();
      w++;
    end
  endtask

  // Called right after reset release on a falling edge (cycle 0)
  task automatic run_init_check(input string tag);
    logic [7:0] exp_cmd [5];
    logic [7:0] seen [5];
    int first_rise;
    int np;
    int done_cyc;
    bit early;
    bit rs_bad;
    bit prev;
    exp_cmd = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    first_rise = -1;
    np = 0;
    done_cyc = -1;
    early = 1'b0;
    rs_bad = 1'b0;
    prev = 1'b0;
    for (int c = 0; c <= 120 && done_cyc < 0; c++) begin
      if (lcd_en === 1'b1 && !prev) begin
        if (first_rise < 0) first_rise = c;
        if (np < 5) begin
          seen[np] = lcd_data;
          if (lcd_rs !== 1'b0 || lcd_rw !== 1'b0) rs_bad = 1'b1;
        end
        np++;
      end
      prev = (lcd_en === 1'b1);
      if (req_ready !== 2'b00 && init_done !== 1'b1) early = 1'b1;
      if (init_done === 1'b1) done_cyc = c;
      else step();
    end
    n_cmp++;
    if (first_rise !== 16) begin
      n_bad++;
      $display("FAIL %s_first_rise got %0d want 16", tag, first_rise);
    end
    n_cmp++;
    if (np !== 5) begin
      n_bad++;
      $display("FAIL %s_pulse_count got %0d want 5", tag, np);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (seen[i] !== exp_cmd[i]) begin
        n_bad++;
        $display("FAIL %s_cmd%0d got %h want %h", tag, i, seen[i], exp_cmd[i]);
      end
    end
    n_cmp++;
    if (rs_bad !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_cmd_rs got rs/rw nonzero want 0", tag);
    end
    n_cmp++;
    if (done_cyc !== 56) begin
      n_bad++;
      $display("FAIL %s_init_done_cycle got %0d want 56", tag, done_cyc);
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_ready_before_init got %b want 0", tag, early);
    end
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    req_rs    = 2'b11;
    req_data  = 16'hFFFF;
    rst_n     = 1'b0;
    step();
    n_cmp++;
    if ({lcd_en, lcd_rs, lcd_rw, init_done, busy} !== 5'b00001) begin
      n_bad++;
      $display("FAIL rst_ctrl got %b want 00001", {lcd_en, lcd_rs, lcd_rw, init_done, busy});
    end
    n_cmp++;
    if (lcd_data !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_lcd_data got %h want 00", lcd_data);
    end
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_req_ready got %b want 00", req_ready);
    end
    n_cmp++;
    if (grant_id !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_grant_id got %b want 0", grant_id);
    end
    req_valid = 2'b00;
    req_rs    = 2'b00;
    req_data  = 16'h0000;
    step();
    rst_n = 1'b1;
    run_init_check("init");
  endtask

  task automatic test_alternate();
    int t [4];
    logic [1:0] rdy [4];
    logic [7:0] dat [4];
    logic rsv [4];
    logic gid [4];
    logic en [4];
    int n;
    int w;
    bit pend;
    n = 0;
    pend = 1'b0;
    req_valid = 2'b11;
    req_rs    = 2'b10;
    req_data  = {8'h48, 8'h80};
    #1;
    for (int c = 0; c < 40; c++) begin
      if (pend) begin
        dat[n] = lcd_data;
        rsv[n] = lcd_rs;
        gid[n] = grant_id;
        en[n]  = lcd_en;
        n++;
        pend = 1'b0;
      end else if (req_ready !== 2'b00 && n < 4) begin
        t[n]   = c;
        rdy[n] = req_ready;
        pend   = 1'b1;
      end
      step();
    end
    req_valid = 2'b00;
    n_cmp++;
    if (n !== 4) begin
      n_bad++;
      $display("FAIL alt_count got %0d want 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (t[i] !== 9 * i) begin
        n_bad++;
        $display("FAIL alt_time%0d got %0d want %0d", i, t[i], 9 * i);
      end
      n_cmp++;
      if ({rdy[i], gid[i], rsv[i], en[i], dat[i]} !==
          ((i % 2 == 1) ? {2'b10, 1'b1, 1'b1, 1'b1, 8'h48} : {2'b01, 1'b0, 1'b0, 1'b1, 8'h80})) begin
        n_bad++;
        $display("FAIL alt_write%0d got rdy=%b gid=%b rs=%b en=%b data=%h", i, rdy[i], gid[i], rsv[i], en[i], dat[i]);
      end
    end
    wait_idle(w);
    n_cmp++;
    if (w >= 200) begin
      n_bad++;
      $display("FAIL alt_idle_timeout got busy=%b want 0", busy);
    end
  endtask

  task automatic test_single();
    int w;
    wait_idle(w);
    req_valid = 2'b01;
    req_rs    = 2'b01;
    req_data  = {8'h00, 8'h41};
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_bad++;
      $display("FAIL single_ready got %b want 01", req_ready);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) req_valid = 2'b00;
      n_cmp++;
      if ({lcd_en, lcd_rs, grant_id, lcd_data} !== {(i < 4), 1'b1, 1'b0, 8'h41}) begin
        n_bad++;
        $display("FAIL single_cyc%0d got en=%b rs=%b gid=%b data=%h want en=%b rs=1 gid=0 data=41",
                 i, lcd_en, lcd_rs, grant_id, lcd_data, (i < 4));
      end
    end
    step();
    n_cmp++;
    if ({busy, lcd_en} !== 2'b00) begin
      n_bad++;
      $display("FAIL single_end got busy=%b en=%b want 0 0", busy, lcd_en);
    end
  endtask

  task automatic test_repeat();
    int hs [3];
    int nh;
    int low;
    int w;
    bit bad_rdy;
    nh = 0;
    low = 0;
    bad_rdy = 1'b0;
    wait_idle(w);
    req_valid = 2'b10;
    req_rs    = 2'b10;
    req_data  = {8'h55, 8'h00};
    #1;
    for (int c = 0; c < 20; c++) begin
      if (busy === 1'b0) low++;
      if (req_ready !== 2'b00) begin
        if (req_ready !== 2'b10) bad_rdy = 1'b1;
        if (nh < 3) hs[nh] = c;
        nh++;
      end
      step();
    end
    req_valid = 2'b00;
    n_cmp++;
    if (nh !== 3) begin
      n_bad++;
      $display("FAIL repeat_count got %0d want 3", nh);
    end
    n_cmp++;
    if ({hs[0], hs[1], hs[2]} !== {32'd0, 32'd9, 32'd18}) begin
      n_bad++;
      $display("FAIL repeat_times got %0d %0d %0d want 0 9 18", hs[0], hs[1], hs[2]);
    end
    n_cmp++;
    if (bad_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL repeat_ready got wrong one-hot want 10");
    end
    n_cmp++;
    if (low !== 3) begin
      n_bad++;
      $display("FAIL repeat_busy_low got %0d want 3", low);
    end
    n_cmp++;
    if ({grant_id, lcd_rs, lcd_data} !== {1'b1, 1'b1, 8'h55}) begin
      n_bad++;
      $display("FAIL repeat_bus got gid=%b rs=%b data=%h want 1 1 55", grant_id, lcd_rs, lcd_data);
    end
  endtask

  task automatic test_init_request();
    int rc;
    logic [1:0] rv;
    logic dn;
    rc = -1;
    rv = 2'b00;
    dn = 1'b0;
    req_valid = 2'b10;
    req_rs    = 2'b10;
    req_data  = {8'h33, 8'h00};
    do_reset();
    for (int c = 0; c <= 120 && rc < 0; c++) begin
      if (req_ready !== 2'b00) begin
        rc = c;
        rv = req_ready;
        dn = init_done;
      end else begin
        step();
      end
    end
    n_cmp++;
    if (rc !== 56) begin
      n_bad++;
      $display("FAIL initreq_cycle got %0d want 56", rc);
    end
    n_cmp++;
    if ({rv, dn} !== 3'b101) begin
      n_bad++;
      $display("FAIL initreq_ready got rdy=%b done=%b want 10 1", rv, dn);
    end
    step();
    req_valid = 2'b00;
    n_cmp++;
    if ({lcd_en, lcd_rs, grant_id, lcd_data} !== {1'b1, 1'b1, 1'b1, 8'h33}) begin
      n_bad++;
      $display("FAIL initreq_write got en=%b rs=%b gid=%b data=%h want 1 1 1 33", lcd_en, lcd_rs, grant_id, lcd_data);
    end
  endtask

  task automatic test_reset_mid_write();
    int w;
    wait_idle(w);
    req_valid = 2'b10;
    req_rs    = 2'b00;
    req_data  = {8'hA5, 8'h00};
    #1;
    step();
    req_valid = 2'b00;
    step();
    step();
    n_cmp++;
    if ({lcd_en, grant_id, lcd_data} !== {1'b1, 1'b1, 8'hA5}) begin
      n_bad++;
      $display("FAIL midrst_pre got en=%b gid=%b data=%h want 1 1 a5", lcd_en, grant_id, lcd_data);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({lcd_en, lcd_rs, init_done, busy} !== 4'b0001) begin
      n_bad++;
      $display("FAIL midrst_ctrl got %b want 0001", {lcd_en, lcd_rs, init_done, busy});
    end
    n_cmp++;
    if ({grant_id, lcd_data} !== 9'h000) begin
      n_bad++;
      $display("FAIL midrst_bus got gid=%b data=%h want 0 00", grant_id, lcd_data);
    end
    step();
    step();
    rst_n = 1'b1;
    run_init_check("reinit");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alternate();
    test_single();
    test_repeat();
    test_init_request();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
